// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle: run/restart controls toward the generator, strobes and
// counters toward renderers and the VGA pins.
interface vga_timing_gen_if #(
  parameter int unsigned CW = 10
);
  logic          en;
  logic          sync_clear;
  logic          p_tick;
  logic [CW-1:0] pixel_x;
  logic [CW-1:0] pixel_y;
  logic          hsync;
  logic          vsync;
  logic          video_on;
  logic          line_start;
  logic          frame_start;

  modport master (
    input  en, sync_clear,
    output p_tick, pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start
  );

  modport slave (
    output en, sync_clear,
    input  p_tick, pixel_x, pixel_y, hsync, vsync, video_on, line_start, frame_start
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: pixel strobe divider, h/v counters and
// registered sync/blanking/line/frame markers decoded from next-state counters.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned CW       = 10
) (
  input  logic             CLK_100MHz,
  input  logic             reset,
  vga_timing_gen_if.master vga
);

  localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HS_START = H_ACTIVE + H_FP;
  localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
  localparam int unsigned VS_START = V_ACTIVE + V_FP;
  localparam int unsigned VS_END   = VS_START + V_SYNC - 1;
  localparam int unsigned DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST   = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] X_LAST     = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] Y_LAST     = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_ACT      = CW'(H_ACTIVE);
  localparam logic [CW-1:0] Y_ACT      = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START_C = CW'(HS_START);
  localparam logic [CW-1:0] HS_END_C   = CW'(HS_END);
  localparam logic [CW-1:0] VS_START_C = CW'(VS_START);
  localparam logic [CW-1:0] VS_END_C   = CW'(VS_END);

  logic [DW-1:0] div_q, div_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic          hs_q, hs_d, vs_q, vs_d, von_q, von_d;
  logic          ls_q, ls_d, fs_q, fs_d;
  logic          tick;

  // Next-state counters; decoded outputs come from the next state so they
  // line up with the counters on the same clock.
  always_comb begin
    div_d = div_q;
    x_d   = x_q;
    y_d   = y_q;
    ls_d  = 1'b0;
    fs_d  = 1'b0;
    tick  = vga.en && (div_q == DIV_LAST);

    if (vga.sync_clear) begin
      div_d = '0;
      x_d   = '0;
      y_d   = '0;
      ls_d  = 1'b1;
      fs_d  = 1'b1;
    end else begin
      if (vga.en) begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      end
      if (tick) begin
        if (x_q == X_LAST) begin
          x_d  = '0;
          ls_d = 1'b1;
          if (y_q == Y_LAST) begin
            y_d  = '0;
            fs_d = 1'b1;
          end else begin
            y_d = y_q + CW'(1);
          end
        end else begin
          x_d = x_q + CW'(1);
        end
      end
    end

    hs_d  = ((x_d >= HS_START_C) && (x_d <= HS_END_C)) ? H_POL : ~H_POL;
    vs_d  = ((y_d >= VS_START_C) && (y_d <= VS_END_C)) ? V_POL : ~V_POL;
    von_d = (x_d < X_ACT) && (y_d < Y_ACT);
  end

  always_ff @(posedge CLK_100MHz or posedge reset) begin
    if (reset) begin
      div_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
      hs_q  <= ~H_POL;
      vs_q  <= ~V_POL;
      von_q <= 1'b0;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      x_q   <= x_d;
      y_q   <= y_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      von_q <= von_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  // p_tick is the only combinational output: it marks the last clock of a pixel.
  assign vga.p_tick      = tick;
  assign vga.pixel_x     = x_q;
  assign vga.pixel_y     = y_q;
  assign vga.hsync       = hs_q;
  assign vga.vsync       = vs_q;
  assign vga.video_on    = von_q;
  assign vga.line_start  = ls_q;
  assign vga.frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three parameterisations checked every clock against a
// linear-pixel-index reference model, plus a hand-computed vector table and timing sequences.
module tb_vga_timing_gen;

  localparam int NI = 3;
  localparam int unsigned HA  [NI] = '{640, 800, 8};
  localparam int unsigned HFP [NI] = '{16, 40, 2};
  localparam int unsigned HSW [NI] = '{96, 128, 3};
  localparam int unsigned HBP [NI] = '{48, 88, 2};
  localparam int unsigned VA  [NI] = '{480, 600, 5};
  localparam int unsigned VFP [NI] = '{10, 1, 1};
  localparam int unsigned VSW [NI] = '{2, 4, 2};
  localparam int unsigned VBP [NI] = '{33, 23, 2};
  localparam int unsigned DV  [NI] = '{4, 1, 3};
  localparam bit          POL [NI] = '{1'b0, 1'b1, 1'b0};
  localparam int unsigned BOUND = 5000;

  typedef struct packed {
    int unsigned x;
    int unsigned y;
    bit tick, hs, vs, von, ls, fs;
  } obs_t;

  typedef struct {
    bit en, sc, tick;
    int unsigned x, y;
    bit ls, fs, von, hs;
  } vec_t;

  logic clk, rst;
  bit   en_v [NI];
  bit   sc_v [NI];
  int   n_checks, n_errors;

  vga_timing_gen_if #(.CW(10)) if_a ();
  vga_timing_gen_if #(.CW(11)) if_b ();
  vga_timing_gen_if #(.CW(4))  if_c ();

  assign if_a.en = en_v[0];  assign if_a.sync_clear = sc_v[0];
  assign if_b.en = en_v[1];  assign if_b.sync_clear = sc_v[1];
  assign if_c.en = en_v[2];  assign if_c.sync_clear = sc_v[2];

  vga_timing_gen dut_a (.CLK_100MHz(clk), .reset(rst), .vga(if_a));

  vga_timing_gen #(
    .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
    .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
    .H_POL(1'b1), .V_POL(1'b1), .CLK_DIV(1), .CW(11)
  ) dut_b (.CLK_100MHz(clk), .reset(rst), .vga(if_b));

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .H_POL(1'b0), .V_POL(1'b0), .CLK_DIV(3), .CW(4)
  ) dut_c (.CLK_100MHz(clk), .reset(rst), .vga(if_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: a phase within the pixel and a linear pixel index per frame.
  int unsigned m_ph [NI], m_pix [NI];
  bit m_ls [NI], m_fs [NI], m_live [NI];
  obs_t last [NI];
  bit tick_seen [NI];

  function automatic int unsigned ht(int i);
    return HA[i] + HFP[i] + HSW[i] + HBP[i];
  endfunction

  function automatic int unsigned vt(int i);
    return VA[i] + VFP[i] + VSW[i] + VBP[i];
  endfunction

  function automatic obs_t model_obs(int i);
    obs_t o;
    int unsigned hs0, vs0;
    o = '0;
    o.x    = m_pix[i] % ht(i);
    o.y    = m_pix[i] / ht(i);
    hs0    = HA[i] + HFP[i];
    vs0    = VA[i] + VFP[i];
    o.tick = en_v[i] && (m_ph[i] == DV[i] - 1);
    o.hs   = (o.x >= hs0 && o.x < hs0 + HSW[i]) ? POL[i] : !POL[i];
    o.vs   = (o.y >= vs0 && o.y < vs0 + VSW[i]) ? POL[i] : !POL[i];
    o.von  = m_live[i] && o.x < HA[i] && o.y < VA[i];
    o.ls   = m_ls[i];
    o.fs   = m_fs[i];
    return o;
  endfunction

  task automatic model_reset_all();
    for (int i = 0; i < NI; i++) begin
      m_ph[i] = 0; m_pix[i] = 0; m_ls[i] = 0; m_fs[i] = 0; m_live[i] = 0;
    end
  endtask

  task automatic model_step(input int i);
    bit t;
    int unsigned frame;
    frame = ht(i) * vt(i);
    t = en_v[i] && (m_ph[i] == DV[i] - 1);
    if (rst) begin
      m_ph[i] = 0; m_pix[i] = 0; m_ls[i] = 0; m_fs[i] = 0; m_live[i] = 0;
    end else begin
      m_live[i] = 1;
      if (sc_v[i]) begin
        m_ph[i] = 0; m_pix[i] = 0; m_ls[i] = 1; m_fs[i] = 1;
      end else if (en_v[i]) begin
        m_ls[i] = t && (m_pix[i] % ht(i) == ht(i) - 1);
        m_fs[i] = t && (m_pix[i] == frame - 1);
        if (t) m_pix[i] = (m_pix[i] + 1) % frame;
        m_ph[i] = (m_ph[i] + 1) % DV[i];
      end else begin
        m_ls[i] = 0; m_fs[i] = 0;
      end
    end
  endtask

  function automatic obs_t mk(int unsigned x, int unsigned y, bit t, bit hs, bit vs,
                              bit von, bit ls, bit fs);
    obs_t o;
    o.x = x; o.y = y; o.tick = t; o.hs = hs; o.vs = vs; o.von = von; o.ls = ls; o.fs = fs;
    return o;
  endfunction

  function automatic obs_t dut_obs(int i);
    case (i)
      0: return mk(32'(if_a.pixel_x), 32'(if_a.pixel_y), if_a.p_tick, if_a.hsync,
                   if_a.vsync, if_a.video_on, if_a.line_start, if_a.frame_start);
      1: return mk(32'(if_b.pixel_x), 32'(if_b.pixel_y), if_b.p_tick, if_b.hsync,
                   if_b.vsync, if_b.video_on, if_b.line_start, if_b.frame_start);
      default: return mk(32'(if_c.pixel_x), 32'(if_c.pixel_y), if_c.p_tick, if_c.hsync,
                         if_c.vsync, if_c.video_on, if_c.line_start, if_c.frame_start);
    endcase
  endfunction

  task automatic chk(input int i, input string nm, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      if (n_errors <= 40)
        $display("FAIL %s inst%0d: got %0d, expected %0d at %0t", nm, i, got, exp, $time);
    end
  endtask

  task automatic chk_regs(input int i, input obs_t g, input obs_t e);
    chk(i, "pixel_x", g.x, e.x);
    chk(i, "pixel_y", g.y, e.y);
    chk(i, "hsync", 32'(g.hs), 32'(e.hs));
    chk(i, "vsync", 32'(g.vs), 32'(e.vs));
    chk(i, "video_on", 32'(g.von), 32'(e.von));
    chk(i, "line_start", 32'(g.ls), 32'(e.ls));
    chk(i, "frame_start", 32'(g.fs), 32'(e.fs));
  endtask

  // One clock: p_tick checked at the falling edge, registers just after the rising edge.
  task automatic cycle();
    obs_t g, e;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      g = dut_obs(i);
      e = model_obs(i);
      chk(i, "p_tick", 32'(g.tick), 32'(e.tick));
      tick_seen[i] = g.tick;
    end
    for (int i = 0; i < NI; i++) model_step(i);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      g = dut_obs(i);
      chk_regs(i, g, model_obs(i));
      last[i] = g;
    end
  endtask

  function automatic bit pulse(int i, bit use_fs);
    return use_fs ? last[i].fs : last[i].ls;
  endfunction

  // Count clocks between successive line/frame pulses, plus active clocks per window.
  task automatic measure(input int i, input bit use_fs, output int unsigned period,
                         output int unsigned hs_act, output int unsigned vs_act,
                         output int unsigned von_n, output int unsigned first_x);
    int unsigned n;
    bit got_x;
    n = 0; period = 0; hs_act = 0; vs_act = 0; von_n = 0; first_x = 0; got_x = 0;
    while (!pulse(i, use_fs) && n < BOUND) begin
      cycle();
      n++;
    end
    chk(i, "pulse_wait_timeout", 32'(n >= BOUND), 0);
    do begin
      if (last[i].hs == POL[i]) begin
        hs_act++;
        if (!got_x) begin first_x = last[i].x; got_x = 1; end
      end
      if (last[i].vs == POL[i]) vs_act++;
      if (last[i].von) von_n++;
      cycle();
      period++;
    end while (!pulse(i, use_fs) && period < BOUND);
  endtask

  vec_t tbl [11];

  initial begin
    int unsigned per, hsa, vsa, von, fx, n, ticks, first_tick, fs_cnt;
    obs_t g, e;
    n_checks = 0; n_errors = 0;
    rst = 1'b1;
    for (int i = 0; i < NI; i++) begin en_v[i] = 0; sc_v[i] = 0; last[i] = '0; end

    // Hand-computed vectors for the CLK_DIV=3 instance starting from reset.
    //           en  sc  tick x  y  ls fs von hs
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[1]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[2]  = '{1, 0, 1, 1, 0, 0, 0, 1, 1};
    tbl[3]  = '{0, 0, 0, 1, 0, 0, 0, 1, 1};
    tbl[4]  = '{1, 0, 0, 1, 0, 0, 0, 1, 1};
    tbl[5]  = '{1, 1, 0, 0, 0, 1, 1, 1, 1};
    tbl[6]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[7]  = '{0, 1, 0, 0, 0, 1, 1, 1, 1};
    tbl[8]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[9]  = '{1, 0, 0, 0, 0, 0, 0, 1, 1};
    tbl[10] = '{1, 0, 1, 1, 0, 0, 0, 1, 1};

    model_reset_all();
    repeat (3) cycle();
    rst = 1'b0;
    en_v[0] = 1; en_v[1] = 1;
    first_tick = 0;
    for (int k = 0; k < 11; k++) begin
      en_v[2] = tbl[k].en;
      sc_v[2] = tbl[k].sc;
      cycle();
      if (first_tick == 0 && tick_seen[0]) first_tick = k + 1;
      chk(2, "tbl_p_tick", 32'(tick_seen[2]), 32'(tbl[k].tick));
      chk(2, "tbl_x", last[2].x, tbl[k].x);
      chk(2, "tbl_y", last[2].y, tbl[k].y);
      chk(2, "tbl_line_start", 32'(last[2].ls), 32'(tbl[k].ls));
      chk(2, "tbl_frame_start", 32'(last[2].fs), 32'(tbl[k].fs));
      chk(2, "tbl_video_on", 32'(last[2].von), 32'(tbl[k].von));
      chk(2, "tbl_hsync", 32'(last[2].hs), 32'(tbl[k].hs));
    end
    chk(0, "first_p_tick_clock", first_tick, 4);
    en_v[2] = 1; sc_v[2] = 0;

    // Default 640x480 line timing from a restart.
    sc_v[0] = 1; cycle(); sc_v[0] = 0;
    measure(0, 0, per, hsa, vsa, von, fx);
    chk(0, "line_period", per, 3200);
    chk(0, "hsync_low_clocks", hsa, 384);
    chk(0, "video_on_clocks", von, 2560);
    chk(0, "hsync_first_x", fx, 656);

    // Pause mid-pixel at x=300, then resume with divider phase intact.
    n = 0;
    while (last[0].x != 300 && n < BOUND) begin cycle(); n++; end
    chk(0, "reach_x300_timeout", 32'(n >= BOUND), 0);
    cycle();
    en_v[0] = 0; ticks = 0;
    repeat (100) begin cycle(); ticks += 32'(tick_seen[0]); end
    chk(0, "paused_x", last[0].x, 300);
    chk(0, "paused_ticks", ticks, 0);
    en_v[0] = 1; n = 0;
    do begin cycle(); n++; end while (!tick_seen[0] && n < 10);
    chk(0, "resume_clocks_to_tick", n, 3);
    chk(0, "resume_x", last[0].x, 301);

    // Restart from inside the hsync pulse.
    n = 0;
    while (last[0].x != 700 && n < BOUND) begin cycle(); n++; end
    chk(0, "reach_x700_timeout", 32'(n >= BOUND), 0);
    sc_v[0] = 1; cycle(); sc_v[0] = 0;
    chk(0, "clr_x", last[0].x, 0);
    chk(0, "clr_y", last[0].y, 0);
    chk(0, "clr_frame_start", 32'(last[0].fs), 1);
    chk(0, "clr_line_start", 32'(last[0].ls), 1);
    chk(0, "clr_hsync", 32'(last[0].hs), 1);
    chk(0, "clr_vsync", 32'(last[0].vs), 1);
    chk(0, "clr_video_on", 32'(last[0].von), 1);

    // 800x600, undivided clock, active-high syncs.
    measure(1, 0, per, hsa, vsa, von, fx);
    chk(1, "line_period", per, 1056);
    chk(1, "hsync_high_clocks", hsa, 128);
    chk(1, "video_on_clocks", von, 800);
    chk(1, "hsync_first_x", fx, 840);

    // Small raster: whole-frame period and vertical decode.
    measure(2, 1, per, hsa, vsa, von, fx);
    chk(2, "frame_period", per, 450);
    chk(2, "hsync_clocks_per_frame", hsa, 90);
    chk(2, "vsync_clocks_per_frame", vsa, 90);
    chk(2, "video_on_per_frame", von, 120);

    n = 0;
    while (!(last[2].x == 11 && last[2].y == 7) && n < BOUND) begin cycle(); n++; end
    chk(2, "reach_sync_timeout", 32'(n >= BOUND), 0);
    sc_v[2] = 1; cycle(); sc_v[2] = 0;
    chk(2, "clr_hsync", 32'(last[2].hs), 1);
    chk(2, "clr_vsync", 32'(last[2].vs), 1);
    chk(2, "clr_xy", last[2].x + last[2].y, 0);
    chk(2, "clr_frame_start", 32'(last[2].fs), 1);

    // Randomised enables and occasional restarts against the model.
    for (int k = 0; k < 20000; k++) begin
      for (int i = 0; i < NI; i++) begin
        en_v[i] = ($urandom_range(0, 7) != 0);
        sc_v[i] = ($urandom_range(0, 511) == 0);
      end
      cycle();
    end

    // Asynchronous reset mid-frame, checked before any clock edge.
    for (int i = 0; i < NI; i++) begin en_v[i] = 0; sc_v[i] = 0; end
    rst = 1'b1;
    #1;
    model_reset_all();
    for (int i = 0; i < NI; i++) begin
      g = dut_obs(i);
      e = model_obs(i);
      chk(i, "async_rst_p_tick", 32'(g.tick), 0);
      chk_regs(i, g, e);
    end
    repeat (2) cycle();
    rst = 1'b0;
    for (int i = 0; i < NI; i++) en_v[i] = 1;
    fs_cnt = 0;
    repeat (60) begin cycle(); fs_cnt += 32'(last[0].fs) + 32'(last[2].fs); end
    chk(0, "no_frame_start_after_reset", fs_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
